clock_divider_multi: RTL and testbench



---
 rtl/clkdiv_pkg.sv | 23 ++
 rtl/clkdiv_channel.sv | 133 +++++++++++++
 rtl/clock_divider_multi.sv | 71 +++++++
 tb/tb_clock_divider_multi.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/clkdiv_pkg.sv
// Shared definitions for the multi-channel clock divider.
//   MODE_TOGGLE / MODE_PULSE : output mode encoding (0 = square wave, 1 = strobe)
//   CLKDIV_CNT_W             : default counter/divisor width
//   ch_state_t               : per-channel state at the default width
package clkdiv_pkg;

  localparam int unsigned CLKDIV_CNT_W = 28;

  typedef enum logic {
    MODE_TOGGLE = 1'b0,
    MODE_PULSE  = 1'b1
  } mode_e;

  typedef struct packed {
    logic [CLKDIV_CNT_W-1:0] cnt;
    logic [CLKDIV_CNT_W-1:0] div;
    mode_e                   mode;
    logic [CLKDIV_CNT_W-1:0] sh_div;
    mode_e                   sh_mode;
    logic                    pend;
  } ch_state_t;

endpackage

// File: rtl/clkdiv_channel.sv
// One divider channel: wrap counter, shadow/apply of divisor+mode, output.
// Ports:
//   clock_in, reset_n   : clock, async active-low reset
//   i_clear             : sync clear of counter/output, applies pending shadow
//   i_enable            : channel enable (disabled channel applies shadow at once)
//   i_advance           : count this cycle (enable, possibly gated by cascade)
//   i_load/i_div/i_mode : shadow capture strobe and data
//   o_wrap              : counter at terminal count on an advancing cycle
//   o_clk               : divided output
//   o_pending           : shadow holds an unapplied update
module clkdiv_channel
  import clkdiv_pkg::*;
#(
  parameter int unsigned CNT_W        = CLKDIV_CNT_W,
  parameter int unsigned DEFAULT_DIV  = 1250,
  parameter int unsigned DEFAULT_MODE = 0
) (
  input  logic             clock_in,
  input  logic             reset_n,
  input  logic             i_clear,
  input  logic             i_enable,
  input  logic             i_advance,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_div,
  input  logic             i_mode,
  output logic             o_wrap,
  output logic             o_clk,
  output logic             o_pending
);

  typedef struct packed {
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] div;
    mode_e            mode;
    logic [CNT_W-1:0] sh_div;
    mode_e            sh_mode;
    logic             pend;
  } chan_t;

  localparam mode_e RST_MODE = (DEFAULT_MODE != 0) ? MODE_PULSE : MODE_TOGGLE;
  localparam logic [CNT_W-1:0] RST_DIV = CNT_W'(DEFAULT_DIV);

  chan_t r_st;
  chan_t w_nxt;
  logic  r_out;
  logic  w_out_nxt;
  logic  w_wrap;
  mode_e w_load_mode;

  assign w_wrap      = i_advance && (r_st.cnt == r_st.div);
  assign w_load_mode = i_mode ? MODE_PULSE : MODE_TOGGLE;

  always_comb begin
    w_nxt     = r_st;
    w_out_nxt = r_out;
    if (i_clear) begin
      w_nxt.cnt  = '0;
      w_out_nxt  = 1'b0;
      if (r_st.pend) begin
        w_nxt.div  = r_st.sh_div;
        w_nxt.mode = r_st.sh_mode;
      end
      w_nxt.pend = 1'b0;
      // a load alongside clear lands after the clear and waits
      if (i_load) begin
        w_nxt.sh_div  = i_div;
        w_nxt.sh_mode = w_load_mode;
        w_nxt.pend    = 1'b1;
      end
    end else begin
      if (w_wrap) begin
        w_nxt.cnt = '0;
        // a load on the wrap cycle bypasses the shadow
        if (i_load) begin
          w_nxt.div     = i_div;
          w_nxt.mode    = w_load_mode;
          w_nxt.sh_div  = i_div;
          w_nxt.sh_mode = w_load_mode;
        end else if (r_st.pend) begin
          w_nxt.div  = r_st.sh_div;
          w_nxt.mode = r_st.sh_mode;
        end
        w_nxt.pend = 1'b0;
      end else begin
        if (i_advance) begin
          w_nxt.cnt = r_st.cnt + CNT_W'(1);
        end
        if (!i_enable && r_st.pend) begin
          w_nxt.div  = r_st.sh_div;
          w_nxt.mode = r_st.sh_mode;
          w_nxt.pend = 1'b0;
        end
        if (i_load) begin
          w_nxt.sh_div  = i_div;
          w_nxt.sh_mode = w_load_mode;
          w_nxt.pend    = 1'b1;
        end
      end

      // output follows the mode in force after this cycle; mode changes at a
      // wrap give 0 (toggle->pulse) or 1 (pulse->toggle)
      if (w_wrap) begin
        if (w_nxt.mode == MODE_PULSE) begin
          w_out_nxt = (r_st.mode == MODE_PULSE);
        end else begin
          w_out_nxt = (r_st.mode == MODE_PULSE) ? 1'b1 : ~r_out;
        end
      end else if (w_nxt.mode == MODE_PULSE) begin
        w_out_nxt = 1'b0;
      end
    end
  end

  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      r_st.cnt     <= '0;
      r_st.div     <= RST_DIV;
      r_st.mode    <= RST_MODE;
      r_st.sh_div  <= RST_DIV;
      r_st.sh_mode <= RST_MODE;
      r_st.pend    <= 1'b0;
      r_out        <= 1'b0;
    end else begin
      r_st  <= w_nxt;
      r_out <= w_out_nxt;
    end
  end

  assign o_wrap    = w_wrap;
  assign o_clk     = r_out;
  assign o_pending = r_st.pend;

endmodule

// File: rtl/clock_divider_multi.sv
// Multi-channel programmable clock divider (toggle or pulse output per channel).
// Ports:
//   clock_in, reset_n : clock, async active-low reset
//   clear             : sync clear of all channels
//   enable[NUM_CH]    : per-channel count enable
//   div_load[NUM_CH]  : per-channel shadow capture strobe
//   div_value, mode_value : shared shadow data
//   clock_out[NUM_CH] : divided outputs
//   div_pending[NUM_CH] : unapplied shadow update present
// Build option: CLKDIV_CASCADE_EN chains channel i-1's wrap into channel i's advance.
module clock_divider_multi
  import clkdiv_pkg::*;
#(
  parameter int unsigned NUM_CH       = 4,
  parameter int unsigned CNT_W        = CLKDIV_CNT_W,
  parameter int unsigned DEFAULT_DIV  = 1250,
  parameter int unsigned DEFAULT_MODE = 0
) (
  input  logic              clock_in,
  input  logic              reset_n,
  input  logic              clear,
  input  logic [NUM_CH-1:0] enable,
  input  logic [NUM_CH-1:0] div_load,
  input  logic [CNT_W-1:0]  div_value,
  input  logic              mode_value,
  output logic [NUM_CH-1:0] clock_out,
  output logic [NUM_CH-1:0] div_pending
);

  logic [NUM_CH-1:0] w_adv;
`ifdef CLKDIV_CASCADE_EN
  logic [NUM_CH-1:0] w_wrap;
`else
  logic [NUM_CH-1:0] w_wrap_unused;
`endif

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
`ifdef CLKDIV_CASCADE_EN
    if (g == 0) begin : g_head
      assign w_adv[g] = enable[g];
    end else begin : g_link
      assign w_adv[g] = enable[g] & w_wrap[g-1];
    end
`else
    assign w_adv[g] = enable[g];
`endif

    clkdiv_channel #(
      .CNT_W       (CNT_W),
      .DEFAULT_DIV (DEFAULT_DIV),
      .DEFAULT_MODE(DEFAULT_MODE)
    ) u_ch (
      .clock_in (clock_in),
      .reset_n  (reset_n),
      .i_clear  (clear),
      .i_enable (enable[g]),
      .i_advance(w_adv[g]),
      .i_load   (div_load[g]),
      .i_div    (div_value),
      .i_mode   (mode_value),
`ifdef CLKDIV_CASCADE_EN
      .o_wrap   (w_wrap[g]),
`else
      .o_wrap   (w_wrap_unused[g]),
`endif
      .o_clk    (clock_out[g]),
      .o_pending(div_pending[g])
    );
  end

endmodule

// File: tb/tb_clock_divider_multi.sv
module tb_clock_divider_multi;

  logic        clk;
  logic        rst_n;
  logic        clear;
  logic [3:0]  enable;
  logic [3:0]  div_load;
  logic [27:0] div_value;
  logic        mode_value;
  logic [3:0]  clock_out;
  logic [3:0]  div_pending;

  int n_cmp = 0;
  int n_bad = 0;

  clock_divider_multi #(
    .NUM_CH      (4),
    .CNT_W       (28),
    .DEFAULT_DIV (1250),
    .DEFAULT_MODE(0)
  ) dut (
    .clock_in   (clk),
    .reset_n    (rst_n),
    .clear      (clear),
    .enable     (enable),
    .div_load   (div_load),
    .div_value  (div_value),
    .mode_value (mode_value),
    .clock_out  (clock_out),
    .div_pending(div_pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  // load while the channel is disabled: captured, then applied the next cycle
  task automatic load_idle(input int ch, input int d, input logic m);
    div_load   = 4'(1 << ch);
    div_value  = 28'(d);
    mode_value = m;
    tick();
    div_load = '0;
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; clear = 1'b0; enable = '0; div_load = '0;
    div_value = '0; mode_value = 1'b0;
    repeat (2) tick();
    n_cmp++;
    if (clock_out !== 4'b0000) begin
      n_bad++; $display("FAIL reset_clock_out: got %b want 0000", clock_out);
    end
    n_cmp++;
    if (div_pending !== 4'b0000) begin
      n_bad++; $display("FAIL reset_pending: got %b want 0000", div_pending);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_toggle_period(input string tag);
    int c;
    enable = 4'b0001;
    c = 0;
    while (clock_out[0] !== 1'b1 && c < 3000) begin tick(); c++; end
    n_cmp++;
    if (c != 1251) begin
      n_bad++; $display("FAIL %s_first_rise: got %0d want 1251", tag, c);
    end
    c = 0;
    while (clock_out[0] === 1'b1 && c < 3000) begin tick(); c++; end
    n_cmp++;
    if (c != 1251) begin
      n_bad++; $display("FAIL %s_high_time: got %0d want 1251", tag, c);
    end
    while (clock_out[0] !== 1'b1 && c < 6000) begin tick(); c++; end
    n_cmp++;
    if (c != 2502) begin
      n_bad++; $display("FAIL %s_period: got %0d want 2502", tag, c);
    end
    enable = '0;
    pulse_clear();
  endtask

  task automatic test_pulse();
    logic [11:0] pat;
    logic [3:0]  pat0;
    div_load = 4'b0010; div_value = 28'd3; mode_value = 1'b1;
    tick();
    div_load = '0;
    n_cmp++;
    if (div_pending !== 4'b0010) begin
      n_bad++; $display("FAIL pulse_pending_set: got %b want 0010", div_pending);
    end
    tick();
    n_cmp++;
    if (div_pending !== 4'b0000) begin
      n_bad++; $display("FAIL pulse_idle_apply: got %b want 0000", div_pending);
    end
    enable = 4'b0010;
    for (int k = 0; k < 12; k++) begin tick(); pat[k] = clock_out[1]; end
    n_cmp++;
    if (pat !== 12'b1000_1000_1000) begin
      n_bad++; $display("FAIL pulse_d3_pattern: got %b want 100010001000", pat);
    end
    enable = '0;
    div_load = 4'b0010; div_value = 28'd0; mode_value = 1'b1;
    tick();
    div_load = '0;
    tick();
    enable = 4'b0010;
    for (int k = 0; k < 4; k++) begin tick(); pat0[k] = clock_out[1]; end
    n_cmp++;
    if (pat0 !== 4'b1111) begin
      n_bad++; $display("FAIL pulse_d0_const: got %b want 1111", pat0);
    end
    enable = '0;
    tick();
    n_cmp++;
    if (clock_out[1] !== 1'b0) begin
      n_bad++; $display("FAIL pulse_disable_low: got %b want 0", clock_out[1]);
    end
  endtask

  task automatic test_glitch_free();
    logic [6:0] pat;
    load_idle(2, 9, 1'b0);
    enable = 4'b0100;
    repeat (4) tick();
    div_load = 4'b0100; div_value = 28'd2; mode_value = 1'b0;
    tick();
    div_load = '0;
    n_cmp++;
    if (div_pending[2] !== 1'b1 || clock_out[2] !== 1'b0) begin
      n_bad++; $display("FAIL gf_pending_after_load: got pend=%b out=%b want pend=1 out=0",
                        div_pending[2], clock_out[2]);
    end
    repeat (4) tick();
    n_cmp++;
    if (div_pending[2] !== 1'b1 || clock_out[2] !== 1'b0) begin
      n_bad++; $display("FAIL gf_pending_before_wrap: got pend=%b out=%b want pend=1 out=0",
                        div_pending[2], clock_out[2]);
    end
    for (int k = 0; k < 7; k++) begin tick(); pat[k] = clock_out[2]; end
    n_cmp++;
    if (pat !== 7'b1000111) begin
      n_bad++; $display("FAIL gf_new_half_period: got %b want 1000111", pat);
    end
    n_cmp++;
    if (div_pending[2] !== 1'b0) begin
      n_bad++; $display("FAIL gf_pending_cleared: got %b want 0", div_pending[2]);
    end
  endtask

  task automatic test_back_to_back();
    logic [6:0] pat;
    logic       seen;
    // channel 2 runs D=2 toggle with counter 0: wraps on the 3rd edge from here
    seen = 1'b0;
    repeat (2) begin tick(); seen |= div_pending[2]; end
    div_load = 4'b0100; div_value = 28'd5; mode_value = 1'b0;
    tick();
    div_load = '0;
    pat[0] = clock_out[2];
    seen |= div_pending[2];
    for (int k = 1; k < 7; k++) begin
      tick(); pat[k] = clock_out[2]; seen |= div_pending[2];
    end
    n_cmp++;
    if (pat !== 7'b1000000) begin
      n_bad++; $display("FAIL b2b_bypass_pattern: got %b want 1000000", pat);
    end
    n_cmp++;
    if (seen !== 1'b0) begin
      n_bad++; $display("FAIL b2b_pending_never: got %b want 0", seen);
    end
    clear = 1'b1;
    div_load = 4'b0100; div_value = 28'd7; mode_value = 1'b0;
    tick();
    clear = 1'b0; div_load = '0;
    n_cmp++;
    if (clock_out !== 4'b0000) begin
      n_bad++; $display("FAIL clr_load_outputs: got %b want 0000", clock_out);
    end
    n_cmp++;
    if (div_pending !== 4'b0100) begin
      n_bad++; $display("FAIL clr_load_pending: got %b want 0100", div_pending);
    end
    tick();
    n_cmp++;
    if (div_pending !== 4'b0100) begin
      n_bad++; $display("FAIL clr_load_still_pending: got %b want 0100", div_pending);
    end
    enable = '0;
    tick();
    n_cmp++;
    if (div_pending !== 4'b0000) begin
      n_bad++; $display("FAIL disabled_apply: got %b want 0000", div_pending);
    end
  endtask

  task automatic test_hold_reset();
    pulse_clear();
    load_idle(3, 9, 1'b0);
    enable = 4'b1000;
    repeat (3) tick();
    enable = '0;
    repeat (5) tick();
    enable = 4'b1000;
    repeat (6) tick();
    n_cmp++;
    if (clock_out[3] !== 1'b0) begin
      n_bad++; $display("FAIL hold_before_wrap: got %b want 0", clock_out[3]);
    end
    tick();
    n_cmp++;
    if (clock_out[3] !== 1'b1) begin
      n_bad++; $display("FAIL hold_wrap_after_resume: got %b want 1", clock_out[3]);
    end
    enable = '0;
    repeat (3) tick();
    n_cmp++;
    if (clock_out[3] !== 1'b1) begin
      n_bad++; $display("FAIL hold_toggle_level: got %b want 1", clock_out[3]);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (clock_out !== 4'b0000 || div_pending !== 4'b0000) begin
      n_bad++; $display("FAIL async_reset: got out=%b pend=%b want 0000/0000",
                        clock_out, div_pending);
    end
    tick();
    rst_n = 1'b1;
    tick();
    test_toggle_period("after_reset");
  endtask

  task automatic test_cascade();
    int r0, r1, f1, hp;
`ifdef CLKDIV_CASCADE_EN
    hp = 20;
`else
    hp = 5;
`endif
    load_idle(0, 3, 1'b0);
    load_idle(1, 4, 1'b0);
    enable = 4'b0011;
    r0 = 0; r1 = 0; f1 = 0;
    for (int c = 1; c <= 60; c++) begin
      tick();
      if (r0 == 0 && clock_out[0] === 1'b1) r0 = c;
      if (r1 == 0 && clock_out[1] === 1'b1) r1 = c;
      if (r1 != 0 && f1 == 0 && clock_out[1] === 1'b0) f1 = c;
    end
    n_cmp++;
    if (r0 != 4) begin
      n_bad++; $display("FAIL chain_ch0_rise: got %0d want 4", r0);
    end
    n_cmp++;
    if (r1 != hp) begin
      n_bad++; $display("FAIL chain_ch1_rise: got %0d want %0d", r1, hp);
    end
    n_cmp++;
    if (f1 != 2 * hp) begin
      n_bad++; $display("FAIL chain_ch1_fall: got %0d want %0d", f1, 2 * hp);
    end
    enable = '0;
  endtask

  initial begin
    test_reset();
    test_toggle_period("toggle");
    test_pulse();
    test_glitch_free();
    test_back_to_back();
    test_hold_reset();
    test_cascade();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
